neureka_tcdm_arbiter: RTL and testbench

Shares one TCDM master port between the NEUREKA streamer sources: feature load, norm load, streamin load and conv store. Arbitration is work-conserving round-robin. Read responses, which return in order, are routed back to the requester that issued them. The block sits between the streamer source/sink FSMs and the tcdm interface driven from the accelerator top. It is controlled by the global clear from neureka_ctrl.

---
 rtl/neureka_tcdm_arbiter.sv | 151 +++++++++++++++
 tb/tb_neureka_tcdm_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neureka_tcdm_arbiter.sv
// Round-robin arbiter that shares one TCDM master port among the NEUREKA streamer sources.
// Read responses come back in order and are routed to their issuer through a small ID FIFO.
module neureka_tcdm_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 256,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic [N_REQ-1:0]                 req_i,
    output logic [N_REQ-1:0]                 gnt_o,
    input  logic [N_REQ-1:0]                 wen_i,
    input  logic [N_REQ*AW-1:0]              add_i,
    input  logic [N_REQ*DW-1:0]              data_i,
    input  logic [N_REQ*DW/8-1:0]            be_i,
    output logic [N_REQ-1:0]                 r_valid_o,
    output logic [DW-1:0]                    r_data_o,
    output logic                             tcdm_req_o,
    input  logic                             tcdm_gnt_i,
    output logic [AW-1:0]                    tcdm_add_o,
    output logic                             tcdm_wen_o,
    output logic [DW/8-1:0]                  tcdm_be_o,
    output logic [DW-1:0]                    tcdm_data_o,
    input  logic                             tcdm_r_valid_i,
    input  logic [DW-1:0]                    tcdm_r_data_i,
    output logic [$clog2(MAX_OUTST+1)-1:0]   outstanding_o,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned BW = DW / 8;

    logic [IW-1:0]    rr_q;
    logic [IW-1:0]    sel;
    logic             any_elig;
    logic [N_REQ-1:0] elig;
    logic             handshake;
    logic             push;
    logic             pop;
    logic [IW-1:0]    head;

    logic [IW-1:0]    fifo_q [MAX_OUTST];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             err_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reads are held back on the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            elig[i] = req_i[i] && (!wen_i[i] || (count_q < CW'(MAX_OUTST)));
        end
    end

    always_comb begin
        int unsigned idx;
        idx      = 0;
        sel      = '0;
        any_elig = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any_elig && elig[IW'(idx)]) begin
                any_elig = 1'b1;
                sel      = IW'(idx);
            end
        end
    end

    always_comb begin
        tcdm_add_o  = '0;
        tcdm_wen_o  = 1'b0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;
        gnt_o       = '0;
        if (any_elig) begin
            tcdm_add_o  = add_i[32'(sel)*AW +: AW];
            tcdm_wen_o  = wen_i[sel];
            tcdm_be_o   = be_i[32'(sel)*BW +: BW];
            tcdm_data_o = data_i[32'(sel)*DW +: DW];
            gnt_o[sel]  = tcdm_gnt_i;
        end
    end

    assign tcdm_req_o = any_elig;
    assign handshake  = any_elig && tcdm_gnt_i;
    assign push       = handshake && tcdm_wen_o && !clear_i;
    assign pop        = tcdm_r_valid_i && (count_q != '0);
    assign head       = fifo_q[rd_ptr_q];

    always_comb begin
        r_valid_o = '0;
        if (pop) begin
            r_valid_o[head] = 1'b1;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (handshake) begin
                rr_q <= (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (tcdm_r_valid_i && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign r_data_o      = tcdm_r_data_i;
    assign outstanding_o = count_q;
    assign busy_o        = (|req_i) || (count_q != '0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_neureka_tcdm_arbiter.sv
// Self-checking bench for neureka_tcdm_arbiter: directed vector table, async reset sequence,
// then randomized traffic compared against a queue-based reference model.
module tb_neureka_tcdm_arbiter;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 256;
    localparam int BW   = DW / 8;
    localparam int MAXO = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      wen = '0;
    logic [N*AW-1:0]   add = '0;
    logic [N*DW-1:0]   wdata = '0;
    logic [N*BW-1:0]   be = '0;
    logic              tcdm_gnt = 1'b0;
    logic              tcdm_r_valid = 1'b0;
    logic [DW-1:0]     tcdm_r_data = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      r_valid;
    logic [DW-1:0]     r_data;
    logic              tcdm_req;
    logic [AW-1:0]     tcdm_add;
    logic              tcdm_wen;
    logic [BW-1:0]     tcdm_be;
    logic [DW-1:0]     tcdm_data;
    logic [2:0]        outstanding;
    logic              busy;
    logic              err;

    int errors = 0;
    int checks = 0;

    // Per-requester payloads held stable until granted
    logic [AW-1:0] p_add  [N];
    logic [DW-1:0] p_data [N];
    logic [BW-1:0] p_be   [N];
    logic [N-1:0]  p_req;
    logic [N-1:0]  p_wen;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] wen;
        logic         gnt;
        logic         rv;
        logic         clr;
        int           sel;
        logic [N-1:0] rvo;
        int           out;
        logic         err;
    } vec_t;

    vec_t tbl[$];

    neureka_tcdm_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_OUTST(MAXO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .req_i          (req),
        .gnt_o          (gnt),
        .wen_i          (wen),
        .add_i          (add),
        .data_i         (wdata),
        .be_i           (be),
        .r_valid_o      (r_valid),
        .r_data_o       (r_data),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_valid_i (tcdm_r_valid),
        .tcdm_r_data_i  (tcdm_r_data),
        .outstanding_o  (outstanding),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [N-1:0] rq, logic [N-1:0] wn, logic g, logic rv, logic clr,
                                int s, logic [N-1:0] rvo, int o, logic e);
        vec_t v;
        v.req = rq; v.wen = wn; v.gnt = g; v.rv = rv; v.clr = clr;
        v.sel = s; v.rvo = rvo; v.out = o; v.err = e;
        return v;
    endfunction

    // First eligible requester searching cyclically from the pointer, -1 if none
    function automatic int model_sel(logic [N-1:0] rq, logic [N-1:0] wn, int rr, int cnt);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (rq[j] && (!wn[j] || cnt < MAXO)) return j;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic clr, input logic g, input logic rv, input logic [DW-1:0] rd);
        clear        = clr;
        tcdm_gnt     = g;
        tcdm_r_valid = rv;
        tcdm_r_data  = rd;
        req          = p_req;
        wen          = p_wen;
        for (int i = 0; i < N; i++) begin
            add[i*AW +: AW]   = p_add[i];
            wdata[i*DW +: DW] = p_data[i];
            be[i*BW +: BW]    = p_be[i];
        end
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int s, input logic g, input logic [N-1:0] exp_rv,
                            input logic [DW-1:0] rd, input int exp_out, input logic exp_err);
        logic [N-1:0] exp_gnt;
        exp_gnt = (g && s >= 0) ? (N'(1) << s) : '0;
        checkOutput($sformatf("%s.tcdm_req", tag), DW'(tcdm_req), DW'(s >= 0));
        checkOutput($sformatf("%s.gnt", tag), DW'(gnt), DW'(exp_gnt));
        checkOutput($sformatf("%s.add", tag), DW'(tcdm_add), (s >= 0) ? DW'(p_add[s]) : '0);
        checkOutput($sformatf("%s.wen", tag), DW'(tcdm_wen), (s >= 0) ? DW'(p_wen[s]) : '0);
        checkOutput($sformatf("%s.be", tag), DW'(tcdm_be), (s >= 0) ? DW'(p_be[s]) : '0);
        checkOutput($sformatf("%s.wdata", tag), tcdm_data, (s >= 0) ? p_data[s] : '0);
        checkOutput($sformatf("%s.r_valid", tag), DW'(r_valid), DW'(exp_rv));
        checkOutput($sformatf("%s.r_data", tag), r_data, rd);
        checkOutput($sformatf("%s.outstanding", tag), DW'(outstanding), DW'(exp_out));
        checkOutput($sformatf("%s.err", tag), DW'(err), DW'(exp_err));
        checkOutput($sformatf("%s.busy", tag), DW'(busy), DW'((|p_req) || exp_out != 0));
    endtask

    initial begin
        int q[$];
        int rr;
        int s;
        logic merr;
        logic g;
        logic rv;
        logic [N-1:0] exp_rv;
        logic [DW-1:0] rd;

        for (int i = 0; i < N; i++) begin
            p_add[i]  = AW'(32'h100 * (i + 1));
            p_data[i] = {8{32'hDA7A_0000 | 32'(i)}};
            p_be[i]   = {8{4'(i + 1)}};
        end
        p_req = '0;
        p_wen = '0;

        // req, wen, gnt, rvalid, clear, sel, r_valid_o, outstanding, err
        tbl.push_back(mk(4'h1, 4'hF, 1, 0, 0,  0, 4'h0, 0, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h1, 1, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 0, 0, -1, 4'h0, 0, 0));
        tbl.push_back(mk(4'hF, 4'hF, 1, 0, 0,  1, 4'h0, 0, 0));
        tbl.push_back(mk(4'hF, 4'hF, 1, 0, 0,  2, 4'h0, 1, 0));
        tbl.push_back(mk(4'hF, 4'hF, 1, 1, 0,  3, 4'h2, 2, 0));
        tbl.push_back(mk(4'hF, 4'hF, 1, 1, 0,  0, 4'h4, 2, 0));
        tbl.push_back(mk(4'hF, 4'hF, 1, 1, 0,  1, 4'h8, 2, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h1, 2, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h2, 1, 0));
        tbl.push_back(mk(4'h4, 4'hF, 1, 0, 0,  2, 4'h0, 0, 0));
        tbl.push_back(mk(4'h1, 4'hF, 1, 0, 0,  0, 4'h0, 1, 0));
        tbl.push_back(mk(4'h2, 4'hF, 1, 0, 0,  1, 4'h0, 2, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h4, 3, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h1, 2, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h2, 1, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'h4, 4'hF, 0, 0, 0, 2, 4'h0, 0, 0));
        tbl.push_back(mk(4'h4, 4'hF, 1, 0, 0,  2, 4'h0, 0, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h4, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(4'h1, 4'hF, 1, 0, 0, 0, 4'h0, i, 0));
        tbl.push_back(mk(4'h1, 4'hF, 1, 0, 0, -1, 4'h0, 4, 0));
        tbl.push_back(mk(4'h9, 4'h1, 1, 0, 0,  3, 4'h0, 4, 0));
        tbl.push_back(mk(4'h1, 4'hF, 1, 1, 0, -1, 4'h1, 4, 0));
        tbl.push_back(mk(4'h1, 4'hF, 1, 0, 0,  0, 4'h0, 3, 0));
        for (int i = 4; i > 0; i--) tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h1, i, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h0, 0, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 0, 0, -1, 4'h0, 0, 1));
        tbl.push_back(mk(4'h0, 4'hF, 1, 0, 1, -1, 4'h0, 0, 1));
        tbl.push_back(mk(4'h0, 4'hF, 1, 0, 0, -1, 4'h0, 0, 0));
        tbl.push_back(mk(4'hF, 4'hF, 1, 0, 0,  0, 4'h0, 0, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h1, 1, 0));
        tbl.push_back(mk(4'h2, 4'hF, 1, 0, 1,  1, 4'h0, 0, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 0, 0, -1, 4'h0, 0, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 1, 0, -1, 4'h0, 0, 0));
        tbl.push_back(mk(4'h0, 4'hF, 1, 0, 0, -1, 4'h0, 0, 1));
        tbl.push_back(mk(4'h0, 4'hF, 1, 0, 1, -1, 4'h0, 0, 1));
        tbl.push_back(mk(4'h0, 4'hF, 1, 0, 0, -1, 4'h0, 0, 0));

        applyStimulus(0, 0, 0, DW'(32'h5A));
        #3;
        checkAll("reset", -1, 0, '0, DW'(32'h5A), 0, 0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < tbl.size(); r++) begin
            p_req = tbl[r].req;
            p_wen = tbl[r].wen;
            rd    = DW'(32'(r) + 32'd169);
            applyStimulus(tbl[r].clr, tbl[r].gnt, tbl[r].rv, rd);
            #3;
            checkAll($sformatf("vec%0d", r), tbl[r].sel, tbl[r].gnt, tbl[r].rvo, rd, tbl[r].out, tbl[r].err);
            @(posedge clk);
            #1;
        end

        // Two reads in flight, then asynchronous reset with a stray response on the bus
        p_req = 4'hF;
        p_wen = 4'hF;
        applyStimulus(0, 1, 0, '0);
        @(posedge clk);
        #1;
        applyStimulus(0, 1, 0, '0);
        @(posedge clk);
        #1;
        p_req = '0;
        applyStimulus(0, 0, 0, DW'(32'hBEEF));
        #2;
        checkOutput("burst.outstanding", DW'(outstanding), DW'(2));
        rst_n        = 1'b0;
        tcdm_r_valid = 1'b1;
        #1;
        checkAll("midreset", -1, 0, '0, DW'(32'hBEEF), 0, 0);
        tcdm_r_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        q.delete();
        rr   = 0;
        merr = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_req[i] && $urandom_range(0, 2) == 0) begin
                    p_req[i] = 1'b1;
                    p_wen[i] = ($urandom_range(0, 3) != 0);
                    p_add[i] = $urandom;
                    p_be[i]  = $urandom;
                    for (int w = 0; w < DW / 32; w++) p_data[i][w*32 +: 32] = $urandom;
                end
            end
            g  = ($urandom_range(0, 3) != 0);
            rv = 1'b0;
            if (q.size() > 0) rv = ($urandom_range(0, 1) == 1);
            else if ($urandom_range(0, 199) == 0) rv = 1'b1;
            rd = '0;
            for (int w = 0; w < DW / 32; w++) rd[w*32 +: 32] = $urandom;
            s      = model_sel(p_req, p_wen, rr, q.size());
            exp_rv = (rv && q.size() > 0) ? (N'(1) << q[0]) : '0;

            applyStimulus(0, g, rv, rd);
            #3;
            checkAll("rand", s, g, exp_rv, rd, q.size(), merr);
            @(posedge clk);
            #1;

            if (rv) begin
                if (q.size() > 0) void'(q.pop_front());
                else merr = 1'b1;
            end
            if (g && s >= 0) begin
                rr = (s + 1) % N;
                if (p_wen[s]) q.push_back(s);
                p_req[s] = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
